// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between a set of requesters and the round-robin arbiter.
// The requester side drives request/acknowledge; the arbiter drives the grant outputs.
interface rr_arbiter_if #(
    parameter int PORTS = 4
);
    localparam int IDX_W = $clog2(PORTS);

    logic [PORTS-1:0] request;
    logic [PORTS-1:0] acknowledge;
    logic [PORTS-1:0] grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_encoded;

    modport master (
        output request,
        output acknowledge,
        input  grant,
        input  grant_valid,
        input  grant_encoded
    );

    modport slave (
        input  request,
        input  acknowledge,
        output grant,
        output grant_valid,
        output grant_encoded
    );
endinterface

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with optional grant holding.
// A mask of strictly-lower-priority ports (relative to the last grant) gives
// rotation; when no masked port requests, the plain priority search wraps around.
module rr_arbiter #(
    parameter int    PORTS         = 4,
    parameter bit    ARB_BLOCK     = 1'b1,
    parameter bit    ARB_BLOCK_ACK = 1'b1,
    parameter string LSB_PRIORITY  = "LOW"
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter_if.slave  arb
);
    localparam int IDX_W      = $clog2(PORTS);
    localparam bit HIGH_FIRST = (LSB_PRIORITY == "HIGH");

    logic [PORTS-1:0] grant_q, grant_d;
    logic [PORTS-1:0] mask_q, mask_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] enc_q, enc_d;

    // Index of the highest-priority set bit; caller guarantees v is non-zero.
    function automatic logic [IDX_W-1:0] pick_idx(input logic [PORTS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        if (HIGH_FIRST) begin
            for (int i = PORTS - 1; i >= 0; i--)
                if (v[i]) r = i[IDX_W-1:0];
        end else begin
            for (int i = 0; i < PORTS; i++)
                if (v[i]) r = i[IDX_W-1:0];
        end
        return r;
    endfunction

    // Set of ports with strictly lower priority than port g.
    function automatic logic [PORTS-1:0] lower_than(input logic [IDX_W-1:0] g);
        logic [PORTS-1:0] m;
        for (int i = 0; i < PORTS; i++)
            m[i] = HIGH_FIRST ? (i > int'(g)) : (i < int'(g));
        return m;
    endfunction

    logic             release_c;
    logic             hold_c;
    logic [PORTS-1:0] masked_c;
    logic [IDX_W-1:0] idx_c;

    // Release detection and hold decision for the current grant.
    always_comb begin
        release_c = 1'b0;
        if (ARB_BLOCK_ACK)
            release_c = |(arb.acknowledge & grant_q);
        else
            release_c = ~|(arb.request & grant_q);
        hold_c   = ARB_BLOCK && valid_q && !release_c;
        masked_c = arb.request & mask_q;
        idx_c    = (|masked_c) ? pick_idx(masked_c) : pick_idx(arb.request);
    end

    // Next grant/mask: keep while held, otherwise arbitrate in the same cycle.
    always_comb begin
        grant_d = grant_q;
        valid_d = valid_q;
        enc_d   = enc_q;
        mask_d  = mask_q;
        if (!hold_c) begin
            if (|arb.request) begin
                grant_d        = '0;
                grant_d[idx_c] = 1'b1;
                valid_d        = 1'b1;
                enc_d          = idx_c;
                mask_d         = lower_than(idx_c);
            end else begin
                grant_d = '0;
                valid_d = 1'b0;
                enc_d   = '0;
            end
        end
    end

    // Grant and mask registers; reset clears the grant and opens the full mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            enc_q   <= '0;
            mask_q  <= '1;
        end else begin
            grant_q <= grant_d;
            valid_q <= valid_d;
            enc_q   <= enc_d;
            mask_q  <= mask_d;
        end
    end

    assign arb.grant         = grant_q;
    assign arb.grant_valid   = valid_q;
    assign arb.grant_encoded = enc_q;
endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL provide parameter PORTS, default 4, the number of requesters (2..32).
REQ-002 SHALL provide parameter ARB_BLOCK, default 1; when 1, a grant is held (not re-arbitrated) until its release condition occurs.
REQ-003 SHALL provide parameter ARB_BLOCK_ACK, default 1; when 1 (with ARB_BLOCK=1), the release condition is acknowledge of the granted port, otherwise it is deassertion of the granted request.
REQ-004 SHALL provide parameter LSB_PRIORITY, default "LOW"; "LOW" gives index 0 the lowest base priority (highest index wins), "HIGH" gives index 0 the highest base priority (lowest index wins).
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port request, input, PORTS, one request bit per requester.
REQ-008 SHALL have port acknowledge, input, PORTS, one release strobe per requester; used only when ARB_BLOCK_ACK=1.
REQ-009 SHALL have port grant, output, PORTS, one-hot (or zero) registered grant vector.
REQ-010 SHALL have port grant_valid, output, 1, high when grant is non-zero.
REQ-011 SHALL have port grant_encoded, output, $clog2(PORTS), binary index of the granted port.

Function
REQ-012 SHALL register grant, grant_valid and grant_encoded; outputs change only on a rising edge of clk or on assertion of rst_n low.
REQ-013 SHALL have one-cycle latency: a request sampled at edge N while idle is granted at edge N (visible after edge N), with no combinational path from request to grant.
REQ-014 SHALL keep grant one-hot or zero at all times; grant_valid SHALL equal |grant; grant_encoded SHALL equal the index of the set grant bit, and 0 when grant_valid=0.
REQ-015 SHALL hold a round-robin mask register; after granting port g, the mask SHALL select only ports of strictly lower priority than g under LSB_PRIORITY ordering.
REQ-016 Arbitration SHALL pick the highest-priority port in (request & mask) if non-zero, else the highest-priority port in request, else no grant.
REQ-017 Hold rule: when grant_valid=1 and ARB_BLOCK=1, the current grant SHALL be kept while the release condition is false; request changes on other ports SHALL be ignored.
REQ-018 Release with ARB_BLOCK_ACK=1: acknowledge[g] sampled high for the granted port g SHALL release; acknowledge bits of non-granted ports SHALL be ignored.
REQ-019 Release with ARB_BLOCK_ACK=0: request[g] sampled low SHALL release.
REQ-020 With ARB_BLOCK=0, SHALL re-arbitrate every cycle (grant rotates among all active requests).
REQ-021 On the release edge, SHALL arbitrate in the same cycle (no idle bubble); the released port MAY be re-granted only if no other port requests.
REQ-022 With ARB_BLOCK_ACK=1, grant SHALL be held even if request[g] drops before acknowledge.
REQ-023 The mask SHALL update only when a new grant is issued; held grants and idle cycles SHALL NOT change the mask.
REQ-024 Wrap-around: when no requesting port is in the mask, selection SHALL fall back to the unmasked search (e.g. index PORTS-1 wraps to 0 under "HIGH").

Reset
REQ-025 While rst_n=0: grant=0, grant_valid=0, grant_encoded=0, mask=all ones (full set).
REQ-026 Reset asserted mid-grant SHALL clear the grant immediately (asynchronously); the first edge after rst_n rises SHALL arbitrate as from idle.

Verification
REQ-027 PORTS=4, "HIGH", ACK=1: request=4'b1111 held, acknowledge of granted port each cycle after grant -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-028 ACK=1: request=4'b0010 for one cycle then 0, no acknowledge -> grant stays 0010, grant_encoded=1, for 10 cycles; acknowledge=4'b0100 -> no change; acknowledge=4'b0010 -> grant=0 next edge.
REQ-029 ARB_BLOCK_ACK=0: grant on port 2 with request 4'b0101; drop request[2] -> grant moves to 0001 on the same release edge (no bubble).
REQ-030 ARB_BLOCK=0, request=4'b1001 constant -> grant alternates 0001, 1000, 0001, ...
REQ-031 Grant on port 3, rst_n pulsed low between edges -> grant=0, grant_valid=0 immediately; after release with request=4'b1000 -> grant 1000 on first edge.
REQ-032 Formal: assert grant one-hot-or-zero, grant_valid==|grant, encoded/one-hot consistency, and no starvation (every held request granted within PORTS grants); cover grant_valid=1 for each port.
